// File: rtl/if_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_pkg
// Shared constants and types for the instruction-fetch stage:
//   RESET_PC_DEFAULT : first fetch address after reset
//   PC_INC_DEFAULT   : byte distance between sequential instructions
//   NOP_WORD         : instruction word presented when no real instruction exists
//   fetch_state_e    : redirect FSM encoding (RUN / BR_PEND)
//   pc_misaligned()  : word-alignment check on a fetch address
// -----------------------------------------------------------------------------
package if_fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] PC_INC_DEFAULT   = 32'd4;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    typedef enum logic {
        RUN     = 1'b0,
        BR_PEND = 1'b1
    } fetch_state_e;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/if_fetch_stage_inst_buf.sv
// -----------------------------------------------------------------------------
// if_inst_buf
// One-entry skid buffer for the instruction SRAM read data. The SRAM only
// presents rdata for one cycle, so when decode stalls on a freshly returned
// word the word is captured here and replayed until it is handed off.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   capture_i  : rdata is fresh this cycle and decode is not accepting it
//   clear_i    : bundle handed to decode this cycle
//   rdata_i    : instruction SRAM read data
//   data_o     : buffered word when valid, otherwise rdata_i
// -----------------------------------------------------------------------------
module if_inst_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        capture_i,
    input  logic        clear_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic        buf_valid_q;
    logic        buf_valid_d;
    logic [31:0] buf_data_q;
    logic [31:0] buf_data_d;

    // Buffer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_data_q  <= 32'h0000_0000;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
        end
    end

    // Capture only into an empty buffer so a held word is never overwritten.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        if (clear_i) begin
            buf_valid_d = 1'b0;
        end else if (capture_i && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            buf_data_d  = rdata_i;
        end else begin
            buf_valid_d = buf_valid_q;
        end
    end

    assign data_o = buf_valid_q ? buf_data_q : rdata_i;

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// MIPS instruction-fetch stage: issues requests to a 1-cycle-latency
// instruction SRAM, holds the returned word while decode stalls, and applies
// taken-branch redirects from decode while honouring the delay slot.
// Optional feature macro: IF_ADEL_EN (adds if_adel_out, suppresses misaligned
// fetches and presents a nop bundle flagged as an address error).
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   id_allowin_in          : decode can accept a bundle this cycle
//   if_valid_out           : bundle on if_* outputs is valid
//   if_PC_out/NPC/NNPC     : PC of held instruction, PC+4, PC+8
//   if_Instruct_out        : instruction word
//   id_br_valid_in         : decode hands a resolved branch this cycle
//   id_brcal_res_in        : branch taken
//   id_bjpc_res_in         : branch/jump target
//   inst_sram_en/addr      : SRAM read request
//   inst_sram_rdata        : SRAM data for previous-cycle request
//   if_adel_out            : (IF_ADEL_EN only) held PC is misaligned
// -----------------------------------------------------------------------------
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_allowin_in,
    output logic        if_valid_out,
    output logic [31:0] if_PC_out,
    output logic [31:0] if_NPC_out,
    output logic [31:0] if_NNPC_out,
    output logic [31:0] if_Instruct_out,
    input  logic        id_br_valid_in,
    input  logic        id_brcal_res_in,
    input  logic [31:0] id_bjpc_res_in,
`ifdef IF_ADEL_EN
    output logic        if_adel_out,
`endif
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata
);

    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  br_target_q, br_target_d;
    logic         issued_q, issued_d;
    fetch_state_e state_q, state_d;

    logic         if_allowin_s;
    logic         taken_s;
    logic         handoff_s;
    logic         redirect_now_s;
    logic [31:0]  next_fetch_s;
    logic [31:0]  buf_word_s;
    logic         adel_s;

    assign if_allowin_s   = !if_valid_q || id_allowin_in;
    assign taken_s        = id_br_valid_in && id_brcal_res_in;
    assign handoff_s      = if_valid_q && id_allowin_in;
    // IF already holds the delay slot, so the target is the very next fetch.
    assign redirect_now_s = taken_s && (state_q == RUN) && if_valid_q;
    assign next_fetch_s   = redirect_now_s ? id_bjpc_res_in : fetch_pc_q;

`ifdef IF_ADEL_EN
    logic adel_q, adel_d;
    assign adel_s       = adel_q;
    assign if_adel_out  = adel_q;
    assign inst_sram_en = if_allowin_s && !rst && !pc_misaligned(next_fetch_s);

    // Address-error flag travels with the PC it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adel_q <= 1'b0;
        end else begin
            adel_q <= adel_d;
        end
    end

    // Sample alignment of each issued address.
    always_comb begin
        adel_d = adel_q;
        if (if_allowin_s) begin
            adel_d = pc_misaligned(next_fetch_s);
        end else begin
            adel_d = adel_q;
        end
    end
`else
    assign adel_s       = 1'b0;
    assign inst_sram_en = if_allowin_s && !rst;
`endif

    assign inst_sram_addr = next_fetch_s;

    if_inst_buf u_inst_buf (
        .clk       (clk),
        .rst       (rst),
        .capture_i (issued_q && !id_allowin_in),
        .clear_i   (handoff_s),
        .rdata_i   (inst_sram_rdata),
        .data_o    (buf_word_s)
    );

    // Fetch state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid_q  <= 1'b0;
            if_pc_q     <= RESET_PC;
            fetch_pc_q  <= RESET_PC;
            br_target_q <= 32'h0000_0000;
            issued_q    <= 1'b0;
            state_q     <= RUN;
        end else begin
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            fetch_pc_q  <= fetch_pc_d;
            br_target_q <= br_target_d;
            issued_q    <= issued_d;
            state_q     <= state_d;
        end
    end

    // Request sequencing and branch-redirect FSM.
    always_comb begin
        if_valid_d  = if_valid_q;
        if_pc_d     = if_pc_q;
        fetch_pc_d  = fetch_pc_q;
        br_target_d = br_target_q;
        state_d     = state_q;
        issued_d    = if_allowin_s;

        if (if_allowin_s) begin
            if_pc_d    = next_fetch_s;
            if_valid_d = 1'b1;
            fetch_pc_d = next_fetch_s + PC_INC;
        end else if (handoff_s) begin
            if_valid_d = 1'b0;
        end else begin
            if_valid_d = if_valid_q;
        end

        case (state_q)
            RUN: begin
                if (taken_s) begin
                    if (if_valid_q) begin
                        // With an issue the target was already sent this cycle.
                        if (!if_allowin_s) begin
                            fetch_pc_d = id_bjpc_res_in;
                        end else begin
                            fetch_pc_d = next_fetch_s + PC_INC;
                        end
                    end else if (if_allowin_s) begin
                        // The request issued now is the delay slot.
                        fetch_pc_d = id_bjpc_res_in;
                    end else begin
                        br_target_d = id_bjpc_res_in;
                        state_d     = BR_PEND;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            BR_PEND: begin
                if (if_allowin_s) begin
                    fetch_pc_d = br_target_q;
                    state_d    = RUN;
                end else begin
                    state_d = BR_PEND;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign if_valid_out    = if_valid_q;
    assign if_PC_out       = if_pc_q;
    assign if_NPC_out      = if_pc_q + PC_INC;
    assign if_NNPC_out     = if_pc_q + PC_INC + PC_INC;
    assign if_Instruct_out = (!if_valid_q || adel_s) ? NOP_WORD : buf_word_s;

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
// Directed, table-driven bench for if_fetch_stage. Each record gives the
// inputs for one cycle and the outputs expected in that cycle; the SRAM data
// column is what a 1-cycle SRAM would return for the previous request.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [31:0] R = 32'hBFC0_0000;

    typedef struct {
        logic        rst_before;
        logic        al;
        logic        brv;
        logic        brt;
        logic [31:0] tgt;
        logic [31:0] rd;
        logic        e_en;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic        e_adel;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_allowin_in = 1'b0;
    logic        if_valid_out;
    logic [31:0] if_PC_out, if_NPC_out, if_NNPC_out, if_Instruct_out;
    logic        id_br_valid_in = 1'b0;
    logic        id_brcal_res_in = 1'b0;
    logic [31:0] id_bjpc_res_in = 32'h0;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata = 32'h0;
`ifdef IF_ADEL_EN
    logic        if_adel_out;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .id_allowin_in   (id_allowin_in),
        .if_valid_out    (if_valid_out),
        .if_PC_out       (if_PC_out),
        .if_NPC_out      (if_NPC_out),
        .if_NNPC_out     (if_NNPC_out),
        .if_Instruct_out (if_Instruct_out),
        .id_br_valid_in  (id_br_valid_in),
        .id_brcal_res_in (id_brcal_res_in),
        .id_bjpc_res_in  (id_bjpc_res_in),
`ifdef IF_ADEL_EN
        .if_adel_out     (if_adel_out),
`endif
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata)
    );

    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @vec %0d: got %08h expected %08h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rb, input logic al, input logic brv, input logic brt,
                       input logic [31:0] tgt, input logic [31:0] rd, input logic en,
                       input logic [31:0] addr, input logic v, input logic [31:0] pc,
                       input logic [31:0] ins, input logic adel = 1'b0);
        vec_t t;
        t.rst_before = rb; t.al = al; t.brv = brv; t.brt = brt; t.tgt = tgt; t.rd = rd;
        t.e_en = en; t.e_addr = addr; t.e_v = v; t.e_pc = pc; t.e_ins = ins; t.e_adel = adel;
        vecs.push_back(t);
    endtask

    task automatic check_outputs(input int idx, input logic en, input logic [31:0] addr,
                                 input logic v, input logic [31:0] pc, input logic [31:0] ins);
        n_vec++;
        chk("sram_en", idx, {31'd0, inst_sram_en}, {31'd0, en});
        chk("sram_addr", idx, inst_sram_addr, addr);
        chk("if_valid", idx, {31'd0, if_valid_out}, {31'd0, v});
        chk("if_pc", idx, if_PC_out, pc);
        chk("if_npc", idx, if_NPC_out, pc + 32'd4);
        chk("if_nnpc", idx, if_NNPC_out, pc + 32'd8);
        chk("if_instr", idx, if_Instruct_out, ins);
    endtask

    // Called at posedge+1; leaves the bench at posedge+1 with rst released.
    task automatic do_reset();
        rst = 1'b1;
        id_allowin_in = 1'b0; id_br_valid_in = 1'b0; id_brcal_res_in = 1'b0;
        id_bjpc_res_in = 32'h0; inst_sram_rdata = 32'h0;
        #3;
        check_outputs(-1, 1'b0, R, 1'b0, R, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic apply(input vec_t t, input int idx);
        if (t.rst_before) do_reset();
        id_allowin_in   = t.al;
        id_br_valid_in  = t.brv;
        id_brcal_res_in = t.brt;
        id_bjpc_res_in  = t.tgt;
        inst_sram_rdata = t.rd;
        #3;
        check_outputs(idx, t.e_en, t.e_addr, t.e_v, t.e_pc, t.e_ins);
`ifdef IF_ADEL_EN
        chk("if_adel", idx, {31'd0, if_adel_out}, {31'd0, t.e_adel});
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Sequential fetch, 3-cycle decode stall with garbage rdata, resume.
        add(1, 1,0,0, 32'h0, 32'h0,               1, R,            0, R,            32'h0);
        add(0, 1,0,0, 32'h0, w(R),                1, R+32'h4,      1, R,            w(R));
        add(0, 1,0,0, 32'h0, w(R+32'h4),          1, R+32'h8,      1, R+32'h4,      w(R+32'h4));
        add(0, 0,0,0, 32'h0, w(R+32'h8),          0, R+32'hC,      1, R+32'h8,      w(R+32'h8));
        add(0, 0,0,0, 32'h0, 32'hDEAD_BEEF,       0, R+32'hC,      1, R+32'h8,      w(R+32'h8));
        add(0, 0,0,0, 32'h0, 32'h0BAD_F00D,       0, R+32'hC,      1, R+32'h8,      w(R+32'h8));
        add(0, 1,0,0, 32'h0, 32'h1234_5678,       1, R+32'hC,      1, R+32'h8,      w(R+32'h8));
        add(0, 1,0,0, 32'h0, w(R+32'hC),          1, R+32'h10,     1, R+32'hC,      w(R+32'hC));
        // Taken branches with the delay slot already in IF.
        add(0, 1,1,1, 32'h100, w(R+32'h10),       1, 32'h100,      1, R+32'h10,     w(R+32'h10));
        add(0, 1,0,0, 32'h0, w(32'h100),          1, 32'h104,      1, 32'h100,      w(32'h100));
        add(0, 1,1,1, 32'h200, w(32'h104),        1, 32'h200,      1, 32'h104,      w(32'h104));
        add(0, 1,0,0, 32'h0, w(32'h200),          1, 32'h204,      1, 32'h200,      w(32'h200));
        // Not-taken and unqualified-taken have no effect.
        add(0, 1,1,0, 32'h400, w(32'h204),        1, 32'h208,      1, 32'h204,      w(32'h204));
        add(0, 1,0,1, 32'h500, w(32'h208),        1, 32'h20C,      1, 32'h208,      w(32'h208));
        // Taken branch during a stall, then wrap-around past 0xFFFFFFFC.
        add(0, 0,1,1, 32'hFFFF_FFFC, w(32'h20C),  0, 32'hFFFF_FFFC, 1, 32'h20C,     w(32'h20C));
        add(0, 1,0,0, 32'h0, 32'h0,               1, 32'hFFFF_FFFC, 1, 32'h20C,     w(32'h20C));
        add(0, 1,0,0, 32'h0, w(32'hFFFF_FFFC),    1, 32'h0,        1, 32'hFFFF_FFFC, w(32'hFFFF_FFFC));
        add(0, 1,0,0, 32'h0, w(32'h0),            1, 32'h4,        1, 32'h0,        w(32'h0));
        // Taken branch while IF is empty: the same-cycle request is the delay slot.
        add(1, 1,1,1, 32'h300, 32'h0,             1, R,            0, R,            32'h0);
        add(0, 1,0,0, 32'h0, w(R),                1, 32'h300,      1, R,            w(R));
        add(0, 1,0,0, 32'h0, w(32'h300),          1, 32'h304,      1, 32'h300,      w(32'h300));
        // Stall so the buffer fills before the mid-stall reset below.
        add(0, 0,0,0, 32'h0, w(32'h304),          0, 32'h308,      1, 32'h304,      w(32'h304));
        add(0, 0,0,0, 32'h0, 32'hEEEE_EEEE,       0, 32'h308,      1, 32'h304,      w(32'h304));

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Reset asserted mid-stall with the buffer full: outputs clear at once.
        id_allowin_in = 1'b0;
        inst_sram_rdata = 32'hEEEE_EEEE;
        #3;
        check_outputs(100, 1'b0, 32'h308, 1'b1, 32'h304, w(32'h304));
        #2;
        rst = 1'b1;
        #1;
        check_outputs(101, 1'b0, R, 1'b0, R, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        id_allowin_in = 1'b1;
        #3;
        check_outputs(102, 1'b1, R, 1'b0, R, 32'h0);
        @(posedge clk);
        #1;
        inst_sram_rdata = w(R);
        #3;
        check_outputs(103, 1'b1, R + 32'h4, 1'b1, R, w(R));
        @(posedge clk);
        #1;

`ifdef IF_ADEL_EN
        // Misaligned jump target: no SRAM read, nop bundle flagged as error.
        vecs.delete();
        add(1, 1,1,1, 32'h202, 32'h0,        1, R,       0, R,       32'h0, 0);
        add(0, 1,0,0, 32'h0, w(R),           0, 32'h202, 1, R,       w(R),  0);
        add(0, 1,0,0, 32'h0, 32'h1111_1111,  0, 32'h206, 1, 32'h202, 32'h0, 1);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], 200 + i);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
